// File: rtl/bus_access_pkg.sv
// Shared types for the backend bus access controller: FSM states, bus targets
// and the per-channel target/direction lookup.
package bus_access_pkg;

    localparam int NUM_CH = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } bus_state_t;

    typedef enum logic [1:0] {
        TGT_ROM = 2'd0,
        TGT_RAM = 2'd1,
        TGT_ALU = 2'd2
    } target_t;

    typedef struct packed {
        target_t tgt;
        logic    is_wr;
    } ch_info_t;

    // ch0 ROM wr, ch1 ROM rd, ch2 RAM wr, ch3 RAM rd, ch4 ALU
    function automatic ch_info_t ch_info(input logic [2:0] ch);
        ch_info_t r;
        r.tgt   = TGT_ROM;
        r.is_wr = 1'b0;
        case (ch)
            3'd0: begin r.tgt = TGT_ROM; r.is_wr = 1'b1; end
            3'd1: begin r.tgt = TGT_ROM; r.is_wr = 1'b0; end
            3'd2: begin r.tgt = TGT_RAM; r.is_wr = 1'b1; end
            3'd3: begin r.tgt = TGT_RAM; r.is_wr = 1'b0; end
            3'd4: begin r.tgt = TGT_ALU; r.is_wr = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_access_ctrl_onehot_decode.sv
// Grant vector decoder: index of the set bit plus an exactly-one-bit-set flag.
module onehot_decode (
    input  logic [4:0] g,
    output logic [2:0] idx,
    output logic       valid
);

    logic [2:0] ones;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 5; i++) begin
            if (g[i]) begin
                ones = ones + 3'd1;
                idx  = 3'(i);
            end
        end
        valid = (ones == 3'd1);
    end

endmodule

// File: rtl/bus_access_ctrl.sv
// Serves one backend bus transaction per arbiter grant period.
// Optional GRANT_CHECK_EN adds a sticky grant_err output for grant protocol violations.
//
// state | meaning
// IDLE  | waiting for a one-hot grant; latches channel, address, data, target
// ISSUE | one-cycle bus_en strobe, counter loaded with target latency - 1
// WAIT  | counting down; captures bus_rdata for reads at zero
// DONE  | one-cycle done pulse to the served channel
// HOLD  | waits for the served grant to drop
module bus_access_ctrl
    import bus_access_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2,
    parameter int RAM_LAT = 1,
    parameter int ALU_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [4:0]                 g,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic                       bus_en,
    output logic                       bus_we,
    output logic [1:0]                 bus_sel,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic [DATA_W-1:0]          bus_rdata,
    output logic [4:0]                 done,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy
`ifdef GRANT_CHECK_EN
    ,
    output logic                       grant_err
`endif
);

    localparam int MAX_LAT = (ROM_LAT > RAM_LAT)
                           ? ((ROM_LAT > ALU_LAT) ? ROM_LAT : ALU_LAT)
                           : ((RAM_LAT > ALU_LAT) ? RAM_LAT : ALU_LAT);
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] ROM_LM1 = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0] RAM_LM1 = CNT_W'(RAM_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_LM1 = CNT_W'(ALU_LAT - 1);

    bus_state_t          state_q, state_d;
    logic [2:0]          ch_q, ch_d;
    target_t             tgt_q, tgt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2:0]          gnt_idx;
    logic                gnt_valid;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    ch_info_t            gnt_info;

    onehot_decode u_dec (
        .g     (g),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == 3'(i)) begin
                addr_sel  = ch_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
        gnt_info = ch_info(gnt_idx);
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tgt_d   = tgt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    ch_d    = gnt_idx;
                    tgt_d   = gnt_info.tgt;
                    wr_d    = gnt_info.is_wr;
                    addr_d  = addr_sel;
                    wdata_d = wdata_sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                case (tgt_q)
                    TGT_RAM: cnt_d = RAM_LM1;
                    TGT_ALU: cnt_d = ALU_LM1;
                    default: cnt_d = ROM_LM1;
                endcase
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!wr_q) rdata_d = bus_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = HOLD;
            HOLD: if (!g[ch_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            tgt_q   <= TGT_ROM;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tgt_q   <= tgt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_en    = (state_q == ISSUE);
    assign bus_we    = (state_q == ISSUE) && wr_q;
    assign bus_sel   = tgt_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        done = '0;
        if (state_q == DONE) done[ch_q] = 1'b1;
    end

`ifdef GRANT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((g != 5'd0) && !gnt_valid) err_d = 1'b1;
        if (((state_q == ISSUE) || (state_q == WAIT)) && !g[ch_q]) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign grant_err = err_q;
`endif

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Directed self-checking bench for bus_access_ctrl (default latencies ROM 2, RAM 1, ALU 3).
module tb_bus_access_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   g;
    logic [39:0]  ch_addr;
    logic [39:0]  ch_wdata;
    logic         bus_en;
    logic         bus_we;
    logic [1:0]   bus_sel;
    logic [7:0]   bus_addr;
    logic [7:0]   bus_wdata;
    logic [7:0]   bus_rdata;
    logic [4:0]   done;
    logic [7:0]   rdata;
    logic         busy;
`ifdef GRANT_CHECK_EN
    logic         grant_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .g         (g),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy)
`ifdef GRANT_CHECK_EN
        ,
        .grant_err (grant_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"},    32'(bus_en),    32'd0);
        chk({tag, "_we"},    32'(bus_we),    32'd0);
        chk({tag, "_sel"},   32'(bus_sel),   32'd0);
        chk({tag, "_addr"},  32'(bus_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_rdata"}, 32'(rdata),     32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        int en_cnt;
        int done_cnt;
        reset     = 1'b1;
        g         = 5'b0;
        bus_rdata = 8'h00;
        // ch4..ch0
        ch_addr   = {8'h07, 8'h2B, 8'h10, 8'h3C, 8'h11};
        ch_wdata  = {8'h09, 8'h66, 8'h55, 8'h44, 8'h33};
        @(negedge clk);
        tick();
        chk_idle_outputs("reset");
`ifdef GRANT_CHECK_EN
        chk("reset_gerr", 32'(grant_err), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // ROM read on ch1
        g = 5'b00010;
        bus_rdata = 8'hFF;
        tick();
        chk("rom_issue_en",   32'(bus_en),   32'd1);
        chk("rom_issue_we",   32'(bus_we),   32'd0);
        chk("rom_issue_sel",  32'(bus_sel),  32'd0);
        chk("rom_issue_addr", 32'(bus_addr), 32'h3C);
        chk("rom_issue_busy", 32'(busy),     32'd1);
        tick();
        chk("rom_wait1_en",   32'(bus_en),   32'd0);
        chk("rom_wait1_addr", 32'(bus_addr), 32'h3C);
        tick();
        chk("rom_wait2_done", 32'(done),     32'd0);
        bus_rdata = 8'hA5;
        tick();
        chk("rom_done",       32'(done),     32'b00010);
        chk("rom_rdata",      32'(rdata),    32'hA5);
        bus_rdata = 8'h00;
        g = 5'b0;
        tick();
        chk("rom_hold_done",  32'(done),     32'd0);
        chk("rom_hold_busy",  32'(busy),     32'd1);
        tick();
        chk("rom_idle_busy",  32'(busy),     32'd0);

        // RAM write on ch2
        g = 5'b00100;
        tick();
        chk("ram_issue_en",    32'(bus_en),    32'd1);
        chk("ram_issue_we",    32'(bus_we),    32'd1);
        chk("ram_issue_sel",   32'(bus_sel),   32'd1);
        chk("ram_issue_addr",  32'(bus_addr),  32'h10);
        chk("ram_issue_wdata", 32'(bus_wdata), 32'h55);
        bus_rdata = 8'h77;
        tick();
        chk("ram_wait_we",     32'(bus_we),    32'd0);
        chk("ram_wait_done",   32'(done),      32'd0);
        tick();
        chk("ram_done",        32'(done),      32'b00100);
        chk("ram_rdata_kept",  32'(rdata),     32'hA5);
        g = 5'b0;
        tick();
        tick();
        chk("ram_idle_busy",   32'(busy),      32'd0);

        // ALU on ch4
        g = 5'b10000;
        bus_rdata = 8'hEE;
        tick();
        chk("alu_issue_en",    32'(bus_en),    32'd1);
        chk("alu_issue_we",    32'(bus_we),    32'd0);
        chk("alu_issue_sel",   32'(bus_sel),   32'd2);
        chk("alu_issue_addr",  32'(bus_addr),  32'h07);
        chk("alu_issue_wdata", 32'(bus_wdata), 32'h09);
        tick();
        tick();
        tick();
        chk("alu_wait3_done",  32'(done),      32'd0);
        bus_rdata = 8'h10;
        tick();
        chk("alu_done",        32'(done),      32'b10000);
        chk("alu_rdata",       32'(rdata),     32'h10);
        bus_rdata = 8'h00;
        g = 5'b0;
        tick();
        tick();
        chk("alu_idle_busy",   32'(busy),      32'd0);

        // Long grant on ch0: exactly one transaction
        g = 5'b00001;
        en_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_en) en_cnt++;
            if (done != 5'd0) done_cnt++;
        end
        chk("hold_en_count",   32'(en_cnt),    32'd1);
        chk("hold_done_count", 32'(done_cnt),  32'd1);
        chk("hold_busy",       32'(busy),      32'd1);
        chk("hold_rdata_kept", 32'(rdata),     32'h10);

        // Switch grant to ch3 while in HOLD: passes through IDLE first
        g = 5'b01000;
        tick();
        chk("regrant_idle_en",   32'(bus_en),   32'd0);
        chk("regrant_idle_busy", 32'(busy),     32'd0);
        tick();
        chk("regrant_issue_en",  32'(bus_en),   32'd1);
        chk("regrant_issue_sel", 32'(bus_sel),  32'd1);
        chk("regrant_issue_addr",32'(bus_addr), 32'h2B);
        bus_rdata = 8'hC3;
        tick();
        tick();
        chk("regrant_done",      32'(done),     32'b01000);
        chk("regrant_rdata",     32'(rdata),    32'hC3);
        g = 5'b0;
        tick();
        tick();

        // Non-one-hot grant is ignored
        g = 5'b00110;
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_en || busy) en_cnt++;
        end
        chk("multi_grant_ignored", 32'(en_cnt), 32'd0);
`ifdef GRANT_CHECK_EN
        chk("multi_grant_gerr", 32'(grant_err), 32'd1);
        g = 5'b0;
        tick();
        chk("multi_grant_gerr_sticky", 32'(grant_err), 32'd1);
`endif
        g = 5'b0;
        tick();

        // Reset during WAIT of a ROM read aborts it
        g = 5'b00010;
        tick();
        tick();
        chk("abort_in_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        g = 5'b0;
        tick();
        chk_idle_outputs("abort");
`ifdef GRANT_CHECK_EN
        chk("abort_gerr_cleared", 32'(grant_err), 32'd0);
`endif
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done != 5'd0) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Grant on ch3 drops during WAIT: transaction still completes
        g = 5'b01000;
        bus_rdata = 8'h5A;
        tick();
        chk("drop_issue_en", 32'(bus_en), 32'd1);
        tick();
        g = 5'b0;
        tick();
        chk("drop_done",  32'(done),  32'b01000);
        chk("drop_rdata", 32'(rdata), 32'h5A);
`ifdef GRANT_CHECK_EN
        chk("drop_gerr",  32'(grant_err), 32'd1);
`endif
        tick();
        chk("drop_hold_busy", 32'(busy), 32'd1);
        tick();
        chk("drop_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_access_ctrl.md
Name: bus_access_ctrl

Overview:
Downstream consumer of the five-way request/grant arbiter. Takes the one-hot grant vector g0..g4, latches the granted channel's address/data, runs one transaction on the shared ROM/RAM/ALU backend bus with per-target fixed latency, and returns a one-cycle done pulse plus read data to the winner. It then holds off until that grant is released, so one grant period carries exactly one transaction.

Parameters:
ADDR_W, 8, address/operand-A width
DATA_W, 8, data/operand-B/result width
ROM_LAT, 2, cycles from issue to ROM data valid (>=1)
RAM_LAT, 1, cycles from issue to RAM data valid (>=1)
ALU_LAT, 3, cycles from issue to ALU result valid (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
g  in  5  grants from arbiter; bit0 ROM write, bit1 ROM read, bit2 RAM write, bit3 RAM read, bit4 ALU
ch_addr  in  5*ADDR_W  per-channel address; channel n at [n*ADDR_W +: ADDR_W]
ch_wdata  in  5*DATA_W  per-channel write data / ALU operand B
bus_en  out  1  backend strobe, one cycle per transaction
bus_we  out  1  write enable (ch0, ch2 only)
bus_sel  out  2  target: 0 ROM, 1 RAM, 2 ALU; 3 unused
bus_addr  out  ADDR_W  latched address / ALU operand A
bus_wdata  out  DATA_W  latched write data / operand B
bus_rdata  in  DATA_W  backend read data / ALU result
done  out  5  one-hot, one-cycle completion pulse for the served channel
rdata  out  DATA_W  captured read result; held until next capture
busy  out  1  high in every state except IDLE

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset: state IDLE, counter 0, bus_en/bus_we/bus_sel/bus_addr/bus_wdata/done/rdata all 0, busy 0. Reset mid-transaction aborts it with no done pulse.
- States are IDLE, ISSUE, WAIT, DONE and HOLD.
- IDLE: if g is exactly one-hot, latch ch index, ch_addr slice, ch_wdata slice and target. Target is ROM for ch0/1, RAM for ch2/3, ALU for ch4. Go to ISSUE. g == 0 or non-one-hot: stay in IDLE and issue nothing.
- ISSUE (1 cycle):
  - bus_en=1; bus_sel/bus_addr/bus_wdata driven from the latches.
  - bus_we=1 only for ch0/ch2.
  - Counter loads target LAT-1; go to WAIT.
- WAIT: bus_en=0; bus_sel/addr/wdata held. Counter decrements each cycle. At 0, capture bus_rdata into rdata for read channels (ch1, ch3, ch4); rdata is unchanged for writes. Go to DONE. Data is captured exactly LAT cycles after the bus_en cycle.
- DONE (1 cycle): done[ch]=1; go to HOLD.
- HOLD: stay while g[ch]=1. When g[ch]=0, go to IDLE. A new grant is accepted in IDLE at the earliest the cycle after.
- Grant drops before DONE: the bus transaction cannot be aborted. It completes, done still pulses, and HOLD exits on the next cycle.
- Grant changes to another channel while busy: ignored until IDLE; the latched ch is used throughout.
- Minimum transaction is 1 (ISSUE) + LAT (WAIT) + 1 (DONE) cycles from IDLE exit, plus at least 1 HOLD cycle.
- Counter width is $clog2(max LAT + 1); no wrap is possible.

Optional Feature:
GRANT_CHECK_EN
- Defined: adds output grant_err (1 bit, sticky, cleared only by reset), which sets on either of:
  - g non-one-hot and non-zero in any cycle;
  - g[ch] falling before DONE.
- Undefined: port absent; both conditions are silently tolerated as described above.

Decomposition:
- Package bus_access_pkg holds:
  - bus_state_t enum: IDLE, ISSUE, WAIT, DONE, HOLD;
  - target_t enum: TGT_ROM=0, TGT_RAM=1, TGT_ALU=2;
  - constants NUM_CH=5 and a channel-to-target/is-write lookup function.
- One sub-module, onehot_decode: 5-bit grant to 3-bit index plus valid (exactly one bit set) flag.

Test Plan:
- ROM read: g=00010, ch_addr[1]=8'h3C, bus_rdata=8'hA5 at capture, ROM_LAT=2 -> bus_en, bus_sel=0, bus_we=0, bus_addr=3C one cycle after grant; rdata=A5 and done=00010 4 cycles after grant.
- RAM write: g=00100, addr=8'h10, wdata=8'h55 -> bus_en+bus_we, sel=1, addr=10, wdata=55; done=00100 3 cycles after grant; rdata unchanged.
- ALU: g=10000, addr=8'h07, wdata=8'h09, rdata=8'h10 -> sel=2, we=0; done=10000 5 cycles after grant; rdata=10.
- Hold/re-grant: keep g=00001 for 10 cycles -> exactly one bus_en pulse. Drop g, then assert g=01000 -> second transaction starts only after IDLE.
- Reset asserted during WAIT of a ROM read -> next cycle all outputs 0, busy 0, no done pulse.
- GRANT_CHECK_EN: apply g=00110 -> no bus_en, grant_err=1 and remains 1. Separately, drop g[3] during WAIT -> done still pulses and grant_err=1.
